// File: rtl/vga_pkg.sv
// Shared constants for the VGA layer compositor: bus widths, transparent key
// and the sprite layer numbers used by the game.
package vga_pkg;

  localparam int unsigned VGA_ADDR_W      = 19;
  localparam int unsigned VGA_IDX_W       = 8;
  localparam int unsigned VGA_TRANSPARENT = 0;

  localparam int unsigned LAYER_BIRD     = 1;
  localparam int unsigned LAYER_PIPE     = 2;
  localparam int unsigned LAYER_NUMBER   = 3;
  localparam int unsigned LAYER_GAMEOVER = 4;
  localparam int unsigned LAYER_TITLE    = 5;

endpackage

// File: rtl/vga_priority_mux.sv
// Combinational fixed-priority select: the highest-numbered enabled layer whose
// index is not the transparent key wins, otherwise the background shows through.
module vga_priority_mux
  import vga_pkg::*;
#(
  parameter int unsigned NUM_LAYERS  = 6,
  parameter int unsigned IDX_W       = VGA_IDX_W,
  parameter int unsigned TRANSPARENT = VGA_TRANSPARENT
) (
  input  logic [NUM_LAYERS-1:0]       en,
  input  logic [NUM_LAYERS*IDX_W-1:0] q,
  input  logic [IDX_W-1:0]            bg_q,
  output logic [IDX_W-1:0]            index
);

  localparam logic [IDX_W-1:0] TRANS_IDX = IDX_W'(TRANSPARENT);

  // Ascending scan so the last opaque match is the highest-priority layer.
  always_comb begin
    index = bg_q;
    for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
      if (en[k] && (q[k*IDX_W +: IDX_W] != TRANS_IDX)) begin
        index = q[k*IDX_W +: IDX_W];
      end
    end
  end

endmodule

// File: rtl/vga_layer_compositor.sv
// Multi-layer sprite compositor between the VGA address generator and the
// colour-board lookup, with frame-synchronous enables and collision detection.
module vga_layer_compositor
  import vga_pkg::*;
#(
  parameter int unsigned NUM_LAYERS  = 6,
  parameter int unsigned ADDR_W      = VGA_ADDR_W,
  parameter int unsigned IDX_W       = VGA_IDX_W,
  parameter int unsigned ROM_LAT     = 1,
  parameter int unsigned TRANSPARENT = VGA_TRANSPARENT,
  parameter int unsigned COLL_A      = LAYER_BIRD,
  parameter int unsigned COLL_B      = LAYER_PIPE
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         pix_valid,
  input  logic [ADDR_W-1:0]            oaddress,
  input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
  input  logic [NUM_LAYERS-1:0]        layer_en_next,
  input  logic                         frame_start,
  output logic [ADDR_W-1:0]            bg_rom_addr,
  output logic [NUM_LAYERS*ADDR_W-1:0] layer_rom_addr,
  input  logic [IDX_W-1:0]             bg_rom_q,
  input  logic [NUM_LAYERS*IDX_W-1:0]  layer_rom_q,
  output logic [IDX_W-1:0]             index,
  output logic                         index_valid,
  output logic [NUM_LAYERS-1:0]        layer_en,
  output logic                         collision,
  output logic                         collision_frame
);

  localparam logic [IDX_W-1:0] TRANS_IDX = IDX_W'(TRANSPARENT);

  // Delay line: each pixel carries the enables it was sampled with.
  logic [ROM_LAT:0]      dl_valid;
  logic [NUM_LAYERS-1:0] dl_en [ROM_LAT+1];

  logic                  out_valid;
  logic [NUM_LAYERS-1:0] out_en;
  logic [IDX_W-1:0]      mux_index;
  logic [IDX_W-1:0]      q_a;
  logic [IDX_W-1:0]      q_b;
  logic                  hit;

  assign out_valid = dl_valid[ROM_LAT];
  assign out_en    = dl_en[ROM_LAT];
  assign q_a       = layer_rom_q[COLL_A*IDX_W +: IDX_W];
  assign q_b       = layer_rom_q[COLL_B*IDX_W +: IDX_W];

  assign hit = out_valid && out_en[COLL_A] && out_en[COLL_B] &&
               (q_a != TRANS_IDX) && (q_b != TRANS_IDX);

  vga_priority_mux #(
    .NUM_LAYERS  (NUM_LAYERS),
    .IDX_W       (IDX_W),
    .TRANSPARENT (TRANSPARENT)
  ) u_priority_mux (
    .en    (out_en),
    .q     (layer_rom_q),
    .bg_q  (bg_rom_q),
    .index (mux_index)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      dl_valid <= '0;
      for (int unsigned i = 0; i <= ROM_LAT; i++) begin
        dl_en[i] <= '0;
      end
    end else begin
      dl_valid[0] <= pix_valid;
      dl_en[0]    <= layer_en;
      for (int unsigned i = 1; i <= ROM_LAT; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_en[i]    <= dl_en[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bg_rom_addr    <= '0;
      layer_rom_addr <= '0;
    end else if (pix_valid) begin
      bg_rom_addr    <= oaddress;
      layer_rom_addr <= layer_addr;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      index       <= '0;
      index_valid <= 1'b0;
    end else begin
      index_valid <= out_valid;
      if (out_valid) begin
        index <= mux_index;
      end
    end
  end

  // A hit landing on frame_start is credited to the frame that is ending.
  always_ff @(posedge clock) begin
    if (reset) begin
      layer_en        <= '0;
      collision       <= 1'b0;
      collision_frame <= 1'b0;
    end else if (frame_start) begin
      layer_en        <= layer_en_next;
      collision_frame <= collision | hit;
      collision       <= 1'b0;
    end else if (hit) begin
      collision <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Scoreboard bench: two compositor instances (ROM latency 1 and 3) driven by
// the same directed pixel stream, each fed by a behavioural ROM model.
module tb_vga_layer_compositor;

  localparam int NL = 6;
  localparam int AW = 19;
  localparam int IW = 8;

  typedef struct {
    logic [IW-1:0] idx;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic pix_valid;
  logic frame_start;
  logic [AW-1:0]    oaddress;
  logic [NL*AW-1:0] layer_addr;
  logic [NL-1:0]    layer_en_next;

  logic [AW-1:0]    a_bg_addr, b_bg_addr;
  logic [NL*AW-1:0] a_l_addr, b_l_addr;
  logic [IW-1:0]    a_bg_q, b_bg_q;
  logic [NL*IW-1:0] a_l_q, b_l_q;
  logic [IW-1:0]    a_index, b_index;
  logic             a_valid, b_valid;
  logic [NL-1:0]    a_en, b_en;
  logic             a_coll, b_coll, a_cf, b_cf;

  logic [(NL+1)*IW-1:0] a_pipe [1];
  logic [(NL+1)*IW-1:0] b_pipe [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pid = 0;
  logic [AW-1:0] last_oaddr;
  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  vga_layer_compositor #(.ROM_LAT(1)) dut_a (
    .clock(clk), .reset(rst), .pix_valid(pix_valid), .oaddress(oaddress),
    .layer_addr(layer_addr), .layer_en_next(layer_en_next), .frame_start(frame_start),
    .bg_rom_addr(a_bg_addr), .layer_rom_addr(a_l_addr), .bg_rom_q(a_bg_q),
    .layer_rom_q(a_l_q), .index(a_index), .index_valid(a_valid), .layer_en(a_en),
    .collision(a_coll), .collision_frame(a_cf)
  );

  vga_layer_compositor #(.ROM_LAT(3)) dut_b (
    .clock(clk), .reset(rst), .pix_valid(pix_valid), .oaddress(oaddress),
    .layer_addr(layer_addr), .layer_en_next(layer_en_next), .frame_start(frame_start),
    .bg_rom_addr(b_bg_addr), .layer_rom_addr(b_l_addr), .bg_rom_q(b_bg_q),
    .layer_rom_q(b_l_q), .index(b_index), .index_valid(b_valid), .layer_en(b_en),
    .collision(b_coll), .collision_frame(b_cf)
  );

  // ROM model: the data byte is the low byte of the address, delayed by the ROM latency.
  function automatic logic [(NL+1)*IW-1:0] rom_bytes(input logic [AW-1:0] bg,
                                                      input logic [NL*AW-1:0] la);
    logic [(NL+1)*IW-1:0] r;
    r[IW-1:0] = bg[IW-1:0];
    for (int k = 0; k < NL; k++) r[(k+1)*IW +: IW] = la[k*AW +: IW];
    return r;
  endfunction

  always @(posedge clk) begin
    a_pipe[0] <= rom_bytes(a_bg_addr, a_l_addr);
    b_pipe[0] <= rom_bytes(b_bg_addr, b_l_addr);
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end

  assign a_bg_q = a_pipe[0][IW-1:0];
  assign a_l_q  = a_pipe[0][(NL+1)*IW-1:IW];
  assign b_bg_q = b_pipe[2][IW-1:0];
  assign b_l_q  = b_pipe[2][(NL+1)*IW-1:IW];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (a_valid) begin
      if (qa.size() == 0) chk("a_unexpected_valid", 64'd1, 64'd0);
      else begin
        ea = qa.pop_front();
        chk("a_index", 64'(a_index), 64'(ea.idx));
        chk("a_emit_cycle", 64'(cyc), 64'(ea.cyc));
      end
    end
    if (b_valid) begin
      if (qb.size() == 0) chk("b_unexpected_valid", 64'd1, 64'd0);
      else begin
        eb = qb.pop_front();
        chk("b_index", 64'(b_index), 64'(eb.idx));
        chk("b_emit_cycle", 64'(cyc), 64'(eb.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pix(input logic [NL*IW-1:0] qs, input logic [IW-1:0] bg,
                     input logic [IW-1:0] req);
    exp_t e;
    pix_valid = 1'b1;
    oaddress  = {11'(pid), bg};
    for (int k = 0; k < NL; k++) layer_addr[k*AW +: AW] = {11'(pid + k), qs[k*IW +: IW]};
    last_oaddr = oaddress;
    e.idx = req;
    e.cyc = cyc + 3;
    qa.push_back(e);
    e.cyc = cyc + 5;
    qb.push_back(e);
    pid++;
    step();
    pix_valid = 1'b0;
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_index"}, 64'(a_index), 64'd0);
    chk({tag, "_a_valid"}, 64'(a_valid), 64'd0);
    chk({tag, "_a_addr"}, 64'(|{a_bg_addr, a_l_addr}), 64'd0);
    chk({tag, "_a_en"}, 64'(a_en), 64'd0);
    chk({tag, "_a_coll"}, 64'({a_coll, a_cf}), 64'd0);
    chk({tag, "_b_index"}, 64'(b_index), 64'd0);
    chk({tag, "_b_valid"}, 64'(b_valid), 64'd0);
    chk({tag, "_b_addr"}, 64'(|{b_bg_addr, b_l_addr}), 64'd0);
    chk({tag, "_b_en"}, 64'(b_en), 64'd0);
    chk({tag, "_b_coll"}, 64'({b_coll, b_cf}), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    pix_valid = 1'b0;
    frame_start = 1'b0;
    oaddress = '0;
    layer_addr = '0;
    layer_en_next = '0;
    idle(3);
    chk_zero("reset");
    rst = 1'b0;
    idle(2);

    // Latency with all layers disabled: background only.
    pix({8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h40}, 8'h2A, 8'h2A);
    chk("a_bg_addr_t1", 64'(a_bg_addr), 64'(last_oaddr));
    chk("b_bg_addr_t1", 64'(b_bg_addr), 64'(last_oaddr));
    idle(6);
    chk("a_index_hold", 64'(a_index), 64'h2A);

    layer_en_next = 6'b000110;
    frame_pulse();
    chk("a_en_update", 64'(a_en), 64'b000110);
    chk("b_en_update", 64'(b_en), 64'b000110);

    // Priority and transparency, back-to-back pixels.
    pix({8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h40}, 8'h3C, 8'h22);
    pix({8'h55, 8'h44, 8'h33, 8'h00, 8'h11, 8'h40}, 8'h3C, 8'h11);
    pix({8'h55, 8'h44, 8'h33, 8'h00, 8'h00, 8'h40}, 8'h5C, 8'h5C);
    pix({8'h55, 8'h44, 8'h33, 8'h00, 8'h00, 8'h40}, 8'h00, 8'h00);
    idle(6);
    chk("a_coll_prio", 64'({a_coll, a_cf}), 64'b10);
    chk("b_coll_prio", 64'({b_coll, b_cf}), 64'b10);
    frame_pulse();
    chk("a_cf_after_prio", 64'({a_coll, a_cf}), 64'b01);
    chk("b_cf_after_prio", 64'({b_coll, b_cf}), 64'b01);

    // Frame where only layer 2 is opaque: no collision.
    pix({8'h55, 8'h44, 8'h33, 8'h22, 8'h00, 8'h40}, 8'h10, 8'h22);
    idle(6);
    chk("a_coll_clean", 64'(a_coll), 64'd0);
    frame_pulse();
    chk("a_cf_clean", 64'({a_coll, a_cf}), 64'b00);
    chk("b_cf_clean", 64'({b_coll, b_cf}), 64'b00);

    // Collision timing: A's hit is visible at t+3, B's at t+5.
    pix({8'h55, 8'h44, 8'h33, 8'h07, 8'h05, 8'h40}, 8'h10, 8'h07);
    step();
    chk("a_coll_t2", 64'(a_coll), 64'd0);
    step();
    chk("a_coll_t3", 64'(a_coll), 64'd1);
    chk("b_coll_t3", 64'(b_coll), 64'd0);
    step();
    chk("b_coll_t4", 64'(b_coll), 64'd0);
    step();
    chk("b_coll_t5", 64'(b_coll), 64'd1);
    frame_pulse();
    chk("a_cf_hit", 64'({a_coll, a_cf}), 64'b01);
    chk("b_cf_hit", 64'({b_coll, b_cf}), 64'b01);
    idle(2);
    frame_pulse();
    chk("a_cf_empty", 64'({a_coll, a_cf}), 64'b00);
    chk("b_cf_empty", 64'({b_coll, b_cf}), 64'b00);

    // frame_start in the cycle of A's hit; B's hit lands two cycles later.
    pix({8'h55, 8'h44, 8'h33, 8'h07, 8'h05, 8'h40}, 8'h10, 8'h07);
    step();
    frame_pulse();
    chk("a_cf_boundary", 64'({a_coll, a_cf}), 64'b01);
    chk("b_cf_boundary", 64'({b_coll, b_cf}), 64'b00);
    idle(2);
    chk("a_coll_boundary_t5", 64'(a_coll), 64'd0);
    chk("b_coll_boundary_t5", 64'(b_coll), 64'd1);

    // Enable shadowing: the pixel alongside frame_start keeps the old enables.
    layer_en_next = 6'b000010;
    frame_start = 1'b1;
    pix({8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h40}, 8'h3C, 8'h22);
    frame_start = 1'b0;
    pix({8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h40}, 8'h3C, 8'h11);
    pix({8'h55, 8'h44, 8'h33, 8'h22, 8'h00, 8'h40}, 8'h3C, 8'h3C);
    chk("a_en_shadow", 64'(a_en), 64'b000010);
    idle(6);

    // Reset with pixels in flight: nothing pending may emerge afterwards.
    for (int i = 0; i < 4; i++) pix({8'h55, 8'h44, 8'h33, 8'h22, 8'h66, 8'h40}, 8'h01, 8'h66);
    rst = 1'b1;
    step();
    rst = 1'b0;
    qa.delete();
    qb.delete();
    chk_zero("midreset");
    idle(8);
    pix({8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h40}, 8'h77, 8'h77);

    for (int i = 0; i < 20 && (qa.size() != 0 || qb.size() != 0); i++) step();
    chk("a_drain", 64'(qa.size()), 64'd0);
    chk("b_drain", 64'(qb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
